// File: rtl/overflow_timer.sv
// Free-running prescaler: emits a registered one-cycle overflow tick every
// COUNT_MAX+1 enabled clock edges, with enable and synchronous clear.
module overflow_timer #(
    parameter  int unsigned COUNT_MAX = 269,
    localparam int unsigned CW        = (COUNT_MAX > 0) ? $clog2(COUNT_MAX + 1) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    output logic          overflow,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] TERMINAL = CW'(COUNT_MAX);

    // Wrap is forced by the terminal compare, so non-power-of-two periods never
    // rely on the natural binary rollover of the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (!en) begin
            overflow <= 1'b0;
        end else if (count == TERMINAL) begin
            count    <= '0;
            overflow <= 1'b1;
        end else begin
            count    <= count + CW'(1);
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_overflow_timer.sv
// Randomized self-checking bench for overflow_timer (COUNT_MAX = 4, 0, 269),
// checked against a model that counts enabled edges since the last restart.
module tb_overflow_timer;

    logic       clk = 1'b0;
    logic       rst_n, en, clr;
    logic       ovf4;
    logic [2:0] count4;

    logic       rst_b, en_b, clr_b;
    logic       ovf0, ovf269;
    logic [0:0] count0;
    logic [8:0] count269;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Model for the COUNT_MAX=4 instance: enabled edges since reset/clear.
    longint k    = 0;
    logic   eovf = 1'b0;
    logic   prev = 1'b0;

    always #5 clk = ~clk;

    overflow_timer #(.COUNT_MAX(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .overflow(ovf4), .count(count4)
    );

    overflow_timer #(.COUNT_MAX(0)) dut0 (
        .clk(clk), .rst_n(rst_b), .en(en_b), .clr(clr_b),
        .overflow(ovf0), .count(count0)
    );

    overflow_timer #(.COUNT_MAX(269)) dut269 (
        .clk(clk), .rst_n(rst_b), .en(en_b), .clr(clr_b),
        .overflow(ovf269), .count(count269)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        k    = 0;
        eovf = 1'b0;
        prev = 1'b0;
    endtask

    // One clock edge of the COUNT_MAX=4 instance, checked 1 time unit later.
    task automatic step4();
        @(posedge clk);
        if (clr) begin
            k    = 0;
            eovf = 1'b0;
        end else if (!en) begin
            eovf = 1'b0;
        end else begin
            k++;
            eovf = (k % 5 == 0);
        end
        #1;
        check("count4", longint'(count4), k % 5);
        check("ovf4", longint'(ovf4), longint'(eovf));
        check("ovf4_double", longint'(ovf4 & prev), 0);
        prev = ovf4;
    endtask

    initial begin
        int unsigned guard;
        int unsigned ticks;
        longint      kb;

        rst_n = 1'b0; en = 1'b0; clr = 1'b0;
        rst_b = 1'b0; en_b = 1'b0; clr_b = 1'b0;
        #12;
        check("rst_count4", longint'(count4), 0);
        check("rst_ovf4", longint'(ovf4), 0);
        check("rst_count269", longint'(count269), 0);
        check("rst_ovf0", longint'(ovf0), 0);

        // Free run for 20 edges: ticks on edges 5, 10, 15, 20.
        rst_n = 1'b1; en = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) step4();

        // Pause for 3 cycles while sitting at the terminal count.
        guard = 0;
        while (k % 5 != 4 && guard < 10) begin step4(); guard++; end
        check("reach_terminal", k % 5, 4);
        en = 1'b0;
        for (int i = 0; i < 3; i++) step4();
        en = 1'b1;
        step4();
        check("deferred_tick", longint'(ovf4), 1);

        // Clear at count 2, then the next tick arrives 5 edges later.
        guard = 0;
        while (k % 5 != 2 && guard < 10) begin step4(); guard++; end
        clr = 1'b1;
        step4();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) step4();
        check("tick_after_clr", longint'(ovf4), 1);

        // Asynchronous reset mid-cycle at count 3.
        guard = 0;
        while (k % 5 != 3 && guard < 10) begin step4(); guard++; end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_count4", longint'(count4), 0);
        check("async_ovf4", longint'(ovf4), 0);
        model_reset();
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) step4();

        // Randomized enable/clear traffic.
        for (int i = 0; i < 500; i++) begin
            en  = ($urandom_range(3) != 0);
            clr = ($urandom_range(15) == 0);
            step4();
        end
        en = 1'b1; clr = 1'b0;

        // COUNT_MAX=0 and COUNT_MAX=269 instances, free running from release.
        rst_b = 1'b1; en_b = 1'b1;
        kb    = 0;
        ticks = 0;
        for (int i = 0; i < 2700; i++) begin
            @(posedge clk);
            kb++;
            #1;
            check("ovf0", longint'(ovf0), 1);
            check("count0", longint'(count0), 0);
            check("count269", longint'(count269), kb % 270);
            check("ovf269", longint'(ovf269), longint'(kb % 270 == 0));
            if (ovf269) ticks++;
        end
        check("ticks269", longint'(ticks), 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
